// File: rtl/copy_engine_scheduler_pkg.sv
// Shared types for the copy-engine scheduler: command record, FSM state set,
// and the Avalon register map. Combinational helpers only, no latency.
// No backpressure of its own; imported by the FIFO and the scheduler top.
package copy_sched_pkg;

  // One queued draw command; the rectangle end coordinates are exclusive.
  typedef struct packed {
    logic [9:0]  x_start;
    logic [9:0]  x_end;
    logic [9:0]  y_start;
    logic [9:0]  y_end;
    logic [19:0] src;
    logic [1:0]  palette;
    logic        flip;
  } draw_cmd_t;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_LOAD  = 2'd1,
    SCHED_RUN   = 2'd2,
    SCHED_CLEAR = 2'd3
  } sched_state_e;

  localparam logic [2:0] ADDR_XRANGE = 3'd0;
  localparam logic [2:0] ADDR_YRANGE = 3'd1;
  localparam logic [2:0] ADDR_SRC    = 3'd2;
  localparam logic [2:0] ADDR_PUSH   = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;
  localparam logic [2:0] ADDR_FLUSH  = 3'd5;
  localparam logic [2:0] ADDR_STATS  = 3'd6;

  // A command with no pixels is retired without ever starting the engine.
  function automatic logic zero_area(draw_cmd_t c);
    return (c.x_end <= c.x_start) || (c.y_end <= c.y_start);
  endfunction

endpackage

// File: rtl/copy_engine_scheduler_if.sv
// Avalon-MM slave bundle for the scheduler's register port.
// Read data is combinational (zero read latency); writes take effect at the next edge.
// No waitrequest: every access completes in the cycle it is presented.
interface copy_engine_scheduler_if;
  logic        AVL_CS;
  logic        AVL_READ;
  logic        AVL_WRITE;
  logic [2:0]  AVL_ADDR;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA;

  modport master (
    output AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_WRITEDATA,
    input  AVL_READDATA
  );

  modport slave (
    input  AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_WRITEDATA,
    output AVL_READDATA
  );
endinterface

// File: rtl/copy_engine_scheduler_cmd_fifo.sv
// Synchronous command FIFO of draw_cmd_t entries with full/empty/count.
// Push visible one cycle later; dout is the head entry, combinational from the read pointer.
// Push while full is dropped; pop while empty is ignored; flush empties in one edge.
// Ports: CLK, RESET (sync, active-high), flush, push, pop, din, dout, full, empty, count.
module cmd_fifo
  import copy_sched_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic      CLK,
  input  logic      RESET,
  input  logic      flush,
  input  logic      push,
  input  logic      pop,
  input  draw_cmd_t din,
  output draw_cmd_t dout,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count
);

  draw_cmd_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Full is judged on the pre-edge count, so a pop in the same cycle
  // does not rescue a push into a full queue.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge CLK) begin
    if (RESET || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/copy_engine_scheduler.sv
// Queues draw commands written over Avalon and hands them one at a time to a copy engine.
// Latency: push into an idle, empty queue raises execute two edges later.
// Backpressure: none on Avalon; pushes into a full queue are dropped and flagged sticky overflow.
// Ports: CLK, RESET (sync, active-high), avl (Avalon slave), dest_*/src_addr_start/
//   palette_index/flip_x command fields, execute, done, queue_idle.
// Optional: define COPY_SCHED_STATS_EN for a completed-command counter at address 6.
module copy_engine_scheduler
  import copy_sched_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SRC_W = 20
) (
  input  logic                   CLK,
  input  logic                   RESET,
  copy_engine_scheduler_if.slave avl,
  output logic [9:0]             dest_x_start,
  output logic [9:0]             dest_x_end,
  output logic [9:0]             dest_y_start,
  output logic [9:0]             dest_y_end,
  output logic [SRC_W-1:0]       src_addr_start,
  output logic [1:0]             palette_index,
  output logic                   flip_x,
  output logic                   execute,
  input  logic                   done,
  output logic                   queue_idle
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE  = SCHED_IDLE;
  localparam logic [1:0] LOAD  = SCHED_LOAD;
  localparam logic [1:0] RUN   = SCHED_RUN;
  localparam logic [1:0] CLEAR = SCHED_CLEAR;

  logic [1:0]  state;
  draw_cmd_t   stage;
  draw_cmd_t   cur;
  draw_cmd_t   head;
  logic        wr_en;
  logic        rd_en;
  logic        push;
  logic        flush;
  logic        pop;
  logic        overflow;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;
  logic [31:0] stats_rd;
  logic [31:0] rdata;
  logic        unused_wdata;

  assign wr_en = avl.AVL_CS && avl.AVL_WRITE;
  assign rd_en = avl.AVL_CS && avl.AVL_READ;
  assign push  = wr_en && (avl.AVL_ADDR == ADDR_PUSH);
  assign flush = wr_en && (avl.AVL_ADDR == ADDR_FLUSH) && avl.AVL_WRITEDATA[0];
  assign pop   = (state == LOAD);
  assign unused_wdata = ^avl.AVL_WRITEDATA[31:26];

  // Staging survives a push so repeated pushes reuse the same fields.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stage <= '0;
    end else if (wr_en) begin
      case (avl.AVL_ADDR)
        ADDR_XRANGE: begin
          stage.x_start <= avl.AVL_WRITEDATA[9:0];
          stage.x_end   <= avl.AVL_WRITEDATA[25:16];
        end
        ADDR_YRANGE: begin
          stage.y_start <= avl.AVL_WRITEDATA[9:0];
          stage.y_end   <= avl.AVL_WRITEDATA[25:16];
        end
        ADDR_SRC: begin
          stage.src     <= avl.AVL_WRITEDATA[19:0];
          stage.palette <= avl.AVL_WRITEDATA[21:20];
          stage.flip    <= avl.AVL_WRITEDATA[22];
        end
        default: ;
      endcase
    end
  end

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (stage),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (RESET || flush)          overflow <= 1'b0;
    else if (push && fifo_full)  overflow <= 1'b1;
  end

  // cur only changes in LOAD, so the engine sees stable fields for all of RUN.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cur   <= '0;
    end else begin
      case (state)
        IDLE:  if (!fifo_empty && !flush) state <= LOAD;
        LOAD: begin
          if (flush) begin
            state <= CLEAR;
          end else begin
            cur   <= head;
            state <= zero_area(head) ? CLEAR : RUN;
          end
        end
        RUN:   if (flush || done) state <= CLEAR;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COPY_SCHED_STATS_EN
  logic [15:0] stats_cnt;

  // Counts both engine-completed commands and zero-area skips.
  always_ff @(posedge CLK) begin
    if (RESET || flush)
      stats_cnt <= '0;
    else if ((state == LOAD && zero_area(head)) || (state == RUN && done))
      stats_cnt <= stats_cnt + 16'd1;
  end

  assign stats_rd = {16'd0, stats_cnt};
`else
  assign stats_rd = '0;
`endif

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (avl.AVL_ADDR)
        ADDR_STATUS: rdata = {8'd0, 8'(fifo_count), 12'd0,
                              overflow, fifo_full, fifo_empty, (state != IDLE)};
        ADDR_STATS:  rdata = stats_rd;
        default:     rdata = '0;
      endcase
    end
  end

  assign avl.AVL_READDATA = rdata;

  assign dest_x_start   = cur.x_start;
  assign dest_x_end     = cur.x_end;
  assign dest_y_start   = cur.y_start;
  assign dest_y_end     = cur.y_end;
  assign src_addr_start = SRC_W'(cur.src);
  assign palette_index  = cur.palette;
  assign flip_x         = cur.flip;
  assign execute        = (state == RUN);
  assign queue_idle     = fifo_empty && (state == IDLE);

endmodule

// File: tb/tb_copy_engine_scheduler.sv
// Scoreboard bench: stimulus pushes expected command vectors, a monitor compares
// the command fields at every execute rise and checks they hold during RUN.
module tb_copy_engine_scheduler;

  localparam int DEPTH = 16;
  localparam int SRC_W = 20;

  typedef logic [62:0] cmd_vec_t;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             done = 1'b0;
  logic [9:0]       dest_x_start, dest_x_end, dest_y_start, dest_y_end;
  logic [SRC_W-1:0] src_addr_start;
  logic [1:0]       palette_index;
  logic             flip_x, execute, queue_idle;
  cmd_vec_t         out_vec;

  int       total = 0;
  int       bad = 0;
  int       exp_stats = 0;
  cmd_vec_t exp_q[$];
  logic     stim_done;

  always #5 CLK = ~CLK;

  copy_engine_scheduler_if avl();

  copy_engine_scheduler #(.DEPTH(DEPTH), .SRC_W(SRC_W)) dut (
    .CLK(CLK), .RESET(RESET), .avl(avl),
    .dest_x_start(dest_x_start), .dest_x_end(dest_x_end),
    .dest_y_start(dest_y_start), .dest_y_end(dest_y_end),
    .src_addr_start(src_addr_start), .palette_index(palette_index),
    .flip_x(flip_x), .execute(execute), .done(done), .queue_idle(queue_idle)
  );

  assign out_vec = {dest_x_start, dest_x_end, dest_y_start, dest_y_end,
                    src_addr_start, palette_index, flip_x};

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic avl_wr(logic [2:0] a, logic [31:0] d);
    @(negedge CLK);
    avl.AVL_CS = 1'b1; avl.AVL_WRITE = 1'b1; avl.AVL_ADDR = a; avl.AVL_WRITEDATA = d;
    @(negedge CLK);
    avl.AVL_CS = 1'b0; avl.AVL_WRITE = 1'b0;
  endtask

  task automatic avl_rd(logic [2:0] a, output logic [31:0] d);
    @(negedge CLK);
    avl.AVL_CS = 1'b1; avl.AVL_READ = 1'b1; avl.AVL_ADDR = a;
    #1 d = avl.AVL_READDATA;
    avl.AVL_CS = 1'b0; avl.AVL_READ = 1'b0;
  endtask

  task automatic stage_cmd(logic [9:0] xs, logic [9:0] xe, logic [9:0] ys, logic [9:0] ye,
                           logic [19:0] src, logic [1:0] pal, logic fl);
    avl_wr(3'd0, {6'd0, xe, 6'd0, xs});
    avl_wr(3'd1, {6'd0, ye, 6'd0, ys});
    avl_wr(3'd2, {9'd0, fl, pal, src});
  endtask

  // Reference: only commands with a non-empty rectangle ever reach the engine.
  task automatic push_cmd(logic [9:0] xs, logic [9:0] xe, logic [9:0] ys, logic [9:0] ye,
                          logic [19:0] src, logic [1:0] pal, logic fl);
    stage_cmd(xs, xe, ys, ye, src, pal, fl);
    if (xe > xs && ye > ys) exp_q.push_back({xs, xe, ys, ye, src, pal, fl});
    avl_wr(3'd3, 32'd0);
  endtask

  task automatic check_stats(string name);
    logic [31:0] d;
    avl_rd(3'd6, d);
`ifdef COPY_SCHED_STATS_EN
    chk(name, 64'(d), 64'(exp_stats & 16'hFFFF));
`else
    chk(name, 64'(d), 64'd0);
`endif
  endtask

  // Monitor: field check on each rising execute, stability while high,
  // and at least three low cycles between consecutive pulses.
  initial begin
    logic     prev, have_prev;
    int       gap;
    cmd_vec_t held;
    prev = 1'b0; have_prev = 1'b0; gap = 0; held = '0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        prev = 1'b0; have_prev = 1'b0; gap = 0;
      end else begin
        if (execute && !prev) begin
          if (have_prev) chk("exec_gap_ge3", 64'(gap >= 3), 64'd1);
          if (exp_q.size() == 0) chk("unexpected_execute", 64'd1, 64'd0);
          else chk("cmd_fields", 64'(out_vec), 64'(exp_q.pop_front()));
          held = out_vec;
        end else if (execute) begin
          chk("run_stable", 64'(out_vec), 64'(held));
        end
        if (!execute && prev) begin have_prev = 1'b1; gap = 0; end
        if (!execute) gap++;
        prev = execute;
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic        seen;
    int          g;
    avl.AVL_CS = 1'b0; avl.AVL_READ = 1'b0; avl.AVL_WRITE = 1'b0;
    avl.AVL_ADDR = '0; avl.AVL_WRITEDATA = '0;
    stim_done = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    chk("rst_execute", 64'(execute), 64'd0);
    chk("rst_queue_idle", 64'(queue_idle), 64'd1);
    chk("rst_outputs", 64'(out_vec), 64'd0);
    avl_rd(3'd4, d);
    chk("rst_status", 64'(d), 64'h2);
    avl_rd(3'd7, d);
    chk("unmapped_read", 64'(d), 64'd0);
    check_stats("rst_stats");

    // Single command: latency of two edges, drop one edge after done
    stage_cmd(10'd10, 10'd20, 10'd5, 10'd8, 20'h100, 2'd0, 1'b0);
    exp_q.push_back({10'd10, 10'd20, 10'd5, 10'd8, 20'h100, 2'd0, 1'b0});
    @(negedge CLK);
    avl.AVL_CS = 1'b1; avl.AVL_WRITE = 1'b1; avl.AVL_ADDR = 3'd3;
    @(posedge CLK);
    @(negedge CLK);
    avl.AVL_CS = 1'b0; avl.AVL_WRITE = 1'b0;
    chk("lat_edge_t", 64'(execute), 64'd0);
    @(negedge CLK);
    chk("lat_edge_t1", 64'(execute), 64'd0);
    @(negedge CLK);
    chk("lat_edge_t2", 64'(execute), 64'd1);
    repeat (29) @(negedge CLK);
    chk("run_held_without_done", 64'(execute), 64'd1);
    done = 1'b1;
    @(negedge CLK);
    done = 1'b0;
    chk("done_drops_execute", 64'(execute), 64'd0);
    chk("clear_not_idle", 64'(queue_idle), 64'd0);
    @(negedge CLK);
    chk("idle_after_clear", 64'(queue_idle), 64'd1);
    exp_stats++;
    check_stats("stats_single");

    // Zero-area command never starts the engine
    push_cmd(10'd50, 10'd50, 10'd0, 10'd10, 20'h3, 2'd1, 1'b1);
    seen = 1'b0;
    repeat (4) begin @(negedge CLK); seen |= execute; end
    chk("zero_area_no_exec", 64'(seen), 64'd0);
    chk("zero_area_idle", 64'(queue_idle), 64'd1);
    exp_stats++;
    check_stats("stats_zero_area");

    // Randomized traffic with a random-latency done responder
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          logic [9:0] xs, xe, ys, ye;
          int k;
          k = 0;
          avl_rd(3'd4, d);
          while (d[23:16] >= 8'd12 && k < 400) begin avl_rd(3'd4, d); k++; end
          xs = 10'($urandom_range(0, 900));
          ys = 10'($urandom_range(1, 900));
          xe = xs + 10'($urandom_range(1, 100));
          ye = ys + 10'($urandom_range(1, 100));
          case ($urandom_range(0, 5))
            0: xe = xs;
            1: ye = ys - 10'd1;
            default: ;
          endcase
          push_cmd(xs, xe, ys, ye, 20'($urandom), 2'($urandom), 1'($urandom));
          repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
        stim_done = 1'b1;
      end
      begin
        g = 0;
        while (!(stim_done && queue_idle) && g < 5000) begin
          @(negedge CLK);
          g++;
          if (execute) begin
            repeat ($urandom_range(0, 5)) @(negedge CLK);
            done = 1'b1;
            @(negedge CLK);
            done = 1'b0;
          end
        end
        chk("random_drain_in_time", 64'(g < 5000), 64'd1);
      end
    join
    chk("random_all_started", 64'(exp_q.size()), 64'd0);
    exp_stats += 20;
    check_stats("stats_random");
    avl_rd(3'd4, d);
    chk("random_status_idle", 64'(d), 64'h2);

    // Flush during the first RUN of four queued commands
    for (int i = 0; i < 4; i++)
      push_cmd(10'(i), 10'(i + 30), 10'd0, 10'd4, 20'(i + 7), 2'(i), 1'(i));
    chk("flush_pre_running", 64'(execute), 64'd1);
    avl_wr(3'd5, 32'd1);
    exp_q.delete();
    exp_stats = 0;
    chk("flush_exec_drop", 64'(execute), 64'd0);
    avl_rd(3'd4, d);
    chk("flush_status_empty", 64'(d), 64'h2);
    seen = 1'b0;
    repeat (10) begin @(negedge CLK); seen |= execute; end
    chk("flush_no_more_exec", 64'(seen), 64'd0);
    check_stats("stats_flush");

    // Overflow: 18 back-to-back pushes, engine never completes. The first
    // command leaves for RUN early, 16 fill the queue, the 18th is dropped.
    stage_cmd(10'd1, 10'd9, 10'd2, 10'd6, 20'hABCDE, 2'd3, 1'b1);
    exp_q.push_back({10'd1, 10'd9, 10'd2, 10'd6, 20'hABCDE, 2'd3, 1'b1});
    @(negedge CLK);
    avl.AVL_CS = 1'b1; avl.AVL_WRITE = 1'b1; avl.AVL_ADDR = 3'd3;
    repeat (18) @(negedge CLK);
    avl.AVL_CS = 1'b0; avl.AVL_WRITE = 1'b0;
    avl_rd(3'd4, d);
    chk("overflow_status", 64'(d), 64'h0010_000D);
    avl_wr(3'd5, 32'd1);
    exp_q.delete();
    repeat (2) @(negedge CLK);
    avl_rd(3'd4, d);
    chk("overflow_cleared", 64'(d), 64'h2);
    check_stats("stats_after_overflow");

    // Reset in the middle of RUN
    push_cmd(10'd100, 10'd200, 10'd100, 10'd150, 20'h55, 2'd2, 1'b0);
    g = 0;
    while (!execute && g < 20) begin @(negedge CLK); g++; end
    chk("rst_run_started", 64'(execute), 64'd1);
    RESET = 1'b1;
    exp_q.delete();
    exp_stats = 0;
    @(negedge CLK);
    chk("rst_mid_execute", 64'(execute), 64'd0);
    chk("rst_mid_outputs", 64'(out_vec), 64'd0);
    RESET = 1'b0;
    avl_rd(3'd4, d);
    chk("rst_mid_status", 64'(d), 64'h2);
    check_stats("stats_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
